// File: rtl/i2c_arb_pkg.sv
// Shared types for the I2C role arbiter: arbitration state encoding and the
// pad level that means "released".
package i2c_arb_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE    = 3'd0,
        ARB_MASTER  = 3'd1,
        ARB_DRAIN_M = 3'd2,
        ARB_SLAVE   = 3'd3,
        ARB_DRAIN_S = 3'd4
    } arb_state_t;

    localparam logic SDA_RELEASED = 1'b1;

endpackage

// File: rtl/i2c_role_arbiter_if.sv
// Core-side and FIFO/pad-side signals of the I2C role arbiter.
// Modport master is the arbiter's view; modport slave is the surrounding I2C top.
interface i2c_role_arbiter_if;

    logic       ms_select;
    logic       SDA_sync;
    logic       SCL_sync;
    logic       busy_master;
    logic       busy_slave;
    logic       SDA_out_master;
    logic       SCL_out_master;
    logic       SDA_out_slave;
    logic       SCL_out_slave;
    logic       TX_read_enable_master;
    logic       TX_read_enable_slave;
    logic       RX_write_enable_master;
    logic       RX_write_enable_slave;
    logic [7:0] rx_data_master;
    logic [7:0] rx_data_slave;
    logic       set_transaction_complete_master;
    logic       set_transaction_complete_slave;
    logic       ack_error_set_master;
    logic       ack_error_set_slave;

    logic       SDA_out;
    logic       SCL_out;
    logic       TX_read_enable;
    logic       RX_write_enable;
    logic [7:0] rx_data;
    logic       set_transaction_complete;
    logic       ack_error_set;
    logic       master_enable;
    logic       slave_enable;
    logic       bus_busy;
    logic       bus_timeout;

    modport master (
        input  ms_select, SDA_sync, SCL_sync, busy_master, busy_slave,
               SDA_out_master, SCL_out_master, SDA_out_slave, SCL_out_slave,
               TX_read_enable_master, TX_read_enable_slave,
               RX_write_enable_master, RX_write_enable_slave,
               rx_data_master, rx_data_slave,
               set_transaction_complete_master, set_transaction_complete_slave,
               ack_error_set_master, ack_error_set_slave,
        output SDA_out, SCL_out, TX_read_enable, RX_write_enable, rx_data,
               set_transaction_complete, ack_error_set,
               master_enable, slave_enable, bus_busy, bus_timeout
    );

    modport slave (
        output ms_select, SDA_sync, SCL_sync, busy_master, busy_slave,
               SDA_out_master, SCL_out_master, SDA_out_slave, SCL_out_slave,
               TX_read_enable_master, TX_read_enable_slave,
               RX_write_enable_master, RX_write_enable_slave,
               rx_data_master, rx_data_slave,
               set_transaction_complete_master, set_transaction_complete_slave,
               ack_error_set_master, ack_error_set_slave,
        input  SDA_out, SCL_out, TX_read_enable, RX_write_enable, rx_data,
               set_transaction_complete, ack_error_set,
               master_enable, slave_enable, bus_busy, bus_timeout
    );

endinterface

// File: rtl/i2c_bus_monitor.sv
// START/STOP detector producing bus_busy. Defining I2C_BUS_TIMEOUT_EN adds a
// stuck-SCL-low timeout that force-releases bus_busy.
module i2c_bus_monitor
    import i2c_arb_pkg::*;
#(
    parameter int unsigned     TO_W           = 16,
    parameter logic [TO_W-1:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic clk,
    input  logic n_rst,
    input  logic SDA_sync,
    input  logic SCL_sync,
    output logic bus_busy,
    output logic bus_timeout
);

    logic sda_prev_r;
    logic bus_busy_r;
    logic start_s;
    logic stop_s;
    logic to_hit_s;

    // Previous SDA sample for edge detection while SCL is high
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sda_prev_r <= SDA_RELEASED;
        end else begin
            sda_prev_r <= SDA_sync;
        end
    end

    assign start_s = SCL_sync & sda_prev_r & ~SDA_sync;
    assign stop_s  = SCL_sync & ~sda_prev_r & SDA_sync;

`ifdef I2C_BUS_TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_LAST = TIMEOUT_CYCLES - {{(TO_W-1){1'b0}}, 1'b1};

    logic [TO_W-1:0] to_cnt_r;

    assign to_hit_s = bus_busy_r & ~SCL_sync & (to_cnt_r == TO_LAST);

    // Count consecutive SCL-low cycles of a busy bus; restart on any release
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            to_cnt_r <= {TO_W{1'b0}};
        end else if (bus_busy_r & ~SCL_sync & ~to_hit_s) begin
            to_cnt_r <= to_cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
        end else begin
            to_cnt_r <= {TO_W{1'b0}};
        end
    end

    assign bus_timeout = to_hit_s;
`else
    logic [TO_W-1:0] timeout_cfg_unused_s;

    assign timeout_cfg_unused_s = TIMEOUT_CYCLES;
    assign to_hit_s             = 1'b0;
    assign bus_timeout          = 1'b0;
`endif

    // Busy from START until STOP; a repeated START leaves it set
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bus_busy_r <= 1'b0;
        end else if (to_hit_s) begin
            bus_busy_r <= 1'b0;
        end else if (start_s) begin
            bus_busy_r <= 1'b1;
        end else if (stop_s) begin
            bus_busy_r <= 1'b0;
        end else begin
            bus_busy_r <= bus_busy_r;
        end
    end

    assign bus_busy = bus_busy_r;

endmodule

// File: rtl/i2c_role_arbiter.sv
// Hands the I2C pads and FIFO ports to either the master or the slave core.
// Optional stuck-bus timeout lives in i2c_bus_monitor (I2C_BUS_TIMEOUT_EN).
module i2c_role_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int unsigned     TO_W           = 16,
    parameter logic [TO_W-1:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic                clk,
    input  logic                n_rst,
    i2c_role_arbiter_if.master  bus
);

    arb_state_t state_r;
    arb_state_t next_state_s;
    logic       bus_busy_s;
    logic       bus_timeout_s;

    i2c_bus_monitor #(
        .TO_W           (TO_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_bus_monitor (
        .clk         (clk),
        .n_rst       (n_rst),
        .SDA_sync    (bus.SDA_sync),
        .SCL_sync    (bus.SCL_sync),
        .bus_busy    (bus_busy_s),
        .bus_timeout (bus_timeout_s)
    );

    assign bus.bus_busy    = bus_busy_s;
    assign bus.bus_timeout = bus_timeout_s;

    // Arbitration state register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r <= ARB_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Role handover: drain the old core, pass through IDLE on a free bus
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ARB_IDLE: begin
                if (bus.ms_select & ~bus_busy_s) begin
                    next_state_s = ARB_MASTER;
                end else if (~bus.ms_select & ~bus_busy_s) begin
                    next_state_s = ARB_SLAVE;
                end else begin
                    next_state_s = ARB_IDLE;
                end
            end
            ARB_MASTER: begin
                if (!bus.ms_select) begin
                    next_state_s = ARB_DRAIN_M;
                end else begin
                    next_state_s = ARB_MASTER;
                end
            end
            ARB_DRAIN_M: begin
                if (bus.ms_select) begin
                    next_state_s = ARB_MASTER;
                end else if (~bus.busy_master & ~bus_busy_s) begin
                    next_state_s = ARB_IDLE;
                end else begin
                    next_state_s = ARB_DRAIN_M;
                end
            end
            ARB_SLAVE: begin
                if (bus.ms_select) begin
                    next_state_s = ARB_DRAIN_S;
                end else begin
                    next_state_s = ARB_SLAVE;
                end
            end
            ARB_DRAIN_S: begin
                if (!bus.ms_select) begin
                    next_state_s = ARB_SLAVE;
                end else if (~bus.busy_slave & ~bus_busy_s) begin
                    next_state_s = ARB_IDLE;
                end else begin
                    next_state_s = ARB_DRAIN_S;
                end
            end
            default: begin
                next_state_s = ARB_IDLE;
            end
        endcase
    end

    assign bus.master_enable = (state_r == ARB_MASTER) || (state_r == ARB_DRAIN_M);
    assign bus.slave_enable  = (state_r == ARB_SLAVE)  || (state_r == ARB_DRAIN_S);

    // Zero-latency mux; IDLE and illegal encodings release the pads
    always_comb begin
        bus.SDA_out                  = SDA_RELEASED;
        bus.SCL_out                  = SDA_RELEASED;
        bus.TX_read_enable           = 1'b0;
        bus.RX_write_enable          = 1'b0;
        bus.rx_data                  = 8'h00;
        bus.set_transaction_complete = 1'b0;
        bus.ack_error_set            = 1'b0;
        case (state_r)
            ARB_MASTER, ARB_DRAIN_M: begin
                bus.SDA_out                  = bus.SDA_out_master;
                bus.SCL_out                  = bus.SCL_out_master;
                bus.TX_read_enable           = bus.TX_read_enable_master;
                bus.RX_write_enable          = bus.RX_write_enable_master;
                bus.rx_data                  = bus.rx_data_master;
                bus.set_transaction_complete = bus.set_transaction_complete_master;
                bus.ack_error_set            = bus.ack_error_set_master;
            end
            ARB_SLAVE, ARB_DRAIN_S: begin
                bus.SDA_out                  = bus.SDA_out_slave;
                bus.SCL_out                  = bus.SCL_out_slave;
                bus.TX_read_enable           = bus.TX_read_enable_slave;
                bus.RX_write_enable          = bus.RX_write_enable_slave;
                bus.rx_data                  = bus.rx_data_slave;
                bus.set_transaction_complete = bus.set_transaction_complete_slave;
                bus.ack_error_set            = bus.ack_error_set_slave;
            end
            default: begin
                bus.SDA_out = SDA_RELEASED;
            end
        endcase
    end

endmodule

// File: tb/tb_i2c_role_arbiter.sv
// Scenario bench for i2c_role_arbiter; expected flag vectors
// {master_enable, slave_enable, bus_busy, bus_timeout} are queued then popped per edge.
module tb_i2c_role_arbiter;

    logic       clk = 1'b0;
    logic       n_rst;
    int         total = 0;
    int         bad = 0;
    logic [3:0] exp_q[$];
    logic [3:0] exp_v;
    logic [3:0] obs;

    i2c_role_arbiter_if arb_if ();

    i2c_role_arbiter #(
        .TO_W           (16),
        .TIMEOUT_CYCLES (16'd8)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (arb_if.master)
    );

    always #5 clk = ~clk;

    assign obs = {arb_if.master_enable, arb_if.slave_enable, arb_if.bus_busy, arb_if.bus_timeout};

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        arb_if.ms_select = 1'b0;
        arb_if.SDA_sync = 1'b1;
        arb_if.SCL_sync = 1'b1;
        arb_if.busy_master = 1'b0;
        arb_if.busy_slave = 1'b0;
        arb_if.SDA_out_master = 1'b0;
        arb_if.SCL_out_master = 1'b0;
        arb_if.TX_read_enable_master = 1'b1;
        arb_if.RX_write_enable_master = 1'b1;
        arb_if.rx_data_master = 8'hA5;
        arb_if.set_transaction_complete_master = 1'b1;
        arb_if.ack_error_set_master = 1'b1;
        arb_if.SDA_out_slave = 1'b0;
        arb_if.SCL_out_slave = 1'b1;
        arb_if.TX_read_enable_slave = 1'b0;
        arb_if.RX_write_enable_slave = 1'b0;
        arb_if.rx_data_slave = 8'h3C;
        arb_if.set_transaction_complete_slave = 1'b0;
        arb_if.ack_error_set_slave = 1'b0;
        repeat (2) cyc();
        total++;
        if (obs !== 4'b0000) begin
            bad++; $display("FAIL reset_flags got=%b exp=%b", obs, 4'b0000);
        end
        total++;
        if ({arb_if.SDA_out, arb_if.SCL_out} !== 2'b11) begin
            bad++; $display("FAIL reset_pads got=%b exp=%b", {arb_if.SDA_out, arb_if.SCL_out}, 2'b11);
        end
        total++;
        if ({arb_if.TX_read_enable, arb_if.RX_write_enable, arb_if.set_transaction_complete,
             arb_if.ack_error_set, arb_if.rx_data} !== 12'h000) begin
            bad++; $display("FAIL reset_strobes got=%h exp=%h", {arb_if.TX_read_enable, arb_if.RX_write_enable,
                arb_if.set_transaction_complete, arb_if.ack_error_set, arb_if.rx_data}, 12'h000);
        end
        n_rst = 1'b1;
        exp_q.push_back(4'b0100);
        cyc();
        exp_v = exp_q.pop_front();
        total++;
        if (obs !== exp_v) begin
            bad++; $display("FAIL first_edge got=%b exp=%b", obs, exp_v);
        end
    endtask

    task automatic test_slave_mux();
        #1;
        total++;
        if ({arb_if.TX_read_enable, arb_if.rx_data} !== {1'b0, 8'h3C}) begin
            bad++; $display("FAIL slave_mask got=%h exp=%h", {arb_if.TX_read_enable, arb_if.rx_data}, {1'b0, 8'h3C});
        end
        total++;
        if ({arb_if.SDA_out, arb_if.SCL_out, arb_if.set_transaction_complete, arb_if.ack_error_set} !== 4'b0100) begin
            bad++; $display("FAIL slave_pads got=%b exp=%b", {arb_if.SDA_out, arb_if.SCL_out,
                arb_if.set_transaction_complete, arb_if.ack_error_set}, 4'b0100);
        end
        arb_if.TX_read_enable_slave = 1'b1;
        arb_if.RX_write_enable_slave = 1'b1;
        arb_if.set_transaction_complete_slave = 1'b1;
        arb_if.ack_error_set_slave = 1'b1;
        arb_if.rx_data_slave = 8'h5A;
        #1;
        total++;
        if ({arb_if.TX_read_enable, arb_if.RX_write_enable, arb_if.set_transaction_complete,
             arb_if.ack_error_set, arb_if.rx_data} !== 12'hF5A) begin
            bad++; $display("FAIL slave_fwd got=%h exp=%h", {arb_if.TX_read_enable, arb_if.RX_write_enable,
                arb_if.set_transaction_complete, arb_if.ack_error_set, arb_if.rx_data}, 12'hF5A);
        end
        arb_if.TX_read_enable_slave = 1'b0;
        arb_if.RX_write_enable_slave = 1'b0;
        arb_if.set_transaction_complete_slave = 1'b0;
        arb_if.ack_error_set_slave = 1'b0;
        arb_if.rx_data_slave = 8'h3C;
    endtask

    task automatic test_drain_abort();
        arb_if.busy_slave = 1'b1;
        arb_if.ms_select = 1'b1;
        repeat (4) exp_q.push_back(4'b0100);
        for (int i = 0; i < 4; i++) begin
            cyc();
            exp_v = exp_q.pop_front();
            total++;
            if (obs !== exp_v) begin
                bad++; $display("FAIL drain_s[%0d] got=%b exp=%b", i, obs, exp_v);
            end
        end
        arb_if.ms_select = 1'b0;
        exp_q.push_back(4'b0100);
        cyc();
        arb_if.busy_slave = 1'b0;
        repeat (3) exp_q.push_back(4'b0100);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) cyc();
            exp_v = exp_q.pop_front();
            total++;
            if (obs !== exp_v) begin
                bad++; $display("FAIL abort[%0d] got=%b exp=%b", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_switch_s_to_m();
        arb_if.ms_select = 1'b1;
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b0000);
        exp_q.push_back(4'b1000);
        exp_q.push_back(4'b1000);
        for (int i = 0; i < 4; i++) begin
            cyc();
            exp_v = exp_q.pop_front();
            total++;
            if (obs !== exp_v) begin
                bad++; $display("FAIL switch_sm[%0d] got=%b exp=%b", i, obs, exp_v);
            end
            if (i == 1) begin
                total++;
                if ({arb_if.SDA_out, arb_if.SCL_out, arb_if.TX_read_enable} !== 3'b110) begin
                    bad++; $display("FAIL idle_pads got=%b exp=%b", {arb_if.SDA_out, arb_if.SCL_out,
                        arb_if.TX_read_enable}, 3'b110);
                end
            end
        end
        total++;
        if ({arb_if.SDA_out, arb_if.TX_read_enable, arb_if.rx_data} !== {2'b01, 8'hA5}) begin
            bad++; $display("FAIL master_fwd got=%h exp=%h", {arb_if.SDA_out, arb_if.TX_read_enable,
                arb_if.rx_data}, {2'b01, 8'hA5});
        end
    endtask

    task automatic test_master_drain();
        arb_if.SDA_sync = 1'b0;
        arb_if.busy_master = 1'b1;
        arb_if.ms_select = 1'b0;
        repeat (21) exp_q.push_back(4'b1010);
        for (int i = 0; i < 21; i++) begin
            cyc();
            exp_v = exp_q.pop_front();
            total++;
            if (obs !== exp_v) begin
                bad++; $display("FAIL drain_m_busy[%0d] got=%b exp=%b", i, obs, exp_v);
            end
        end
        total++;
        if ({arb_if.TX_read_enable, arb_if.rx_data} !== {1'b1, 8'hA5}) begin
            bad++; $display("FAIL drain_m_fwd got=%h exp=%h", {arb_if.TX_read_enable, arb_if.rx_data}, {1'b1, 8'hA5});
        end
        arb_if.busy_master = 1'b0;
        repeat (2) exp_q.push_back(4'b1010);
        for (int i = 0; i < 2; i++) begin
            cyc();
            exp_v = exp_q.pop_front();
            total++;
            if (obs !== exp_v) begin
                bad++; $display("FAIL drain_m_bus[%0d] got=%b exp=%b", i, obs, exp_v);
            end
        end
        arb_if.SDA_sync = 1'b1;
        exp_q.push_back(4'b1000);
        exp_q.push_back(4'b0000);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b0100);
        for (int i = 0; i < 4; i++) begin
            cyc();
            exp_v = exp_q.pop_front();
            total++;
            if (obs !== exp_v) begin
                bad++; $display("FAIL drain_m_stop[%0d] got=%b exp=%b", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_idle_busy();
        logic [1:0] seq [5];
        seq[0] = 2'b00; seq[1] = 2'b01; seq[2] = 2'b11; seq[3] = 2'b10; seq[4] = 2'b10;
        arb_if.ms_select = 1'b1;
        exp_q.push_back(4'b0100);
        cyc();
        exp_v = exp_q.pop_front();
        total++;
        if (obs !== exp_v) begin
            bad++; $display("FAIL idle_busy_drain got=%b exp=%b", obs, exp_v);
        end
        arb_if.SDA_sync = 1'b0;
        exp_q.push_back(4'b0010);
        cyc();
        for (int i = 0; i < 6; i++) begin
            exp_v = exp_q.pop_front();
            total++;
            if (obs !== exp_v) begin
                bad++; $display("FAIL idle_busy[%0d] got=%b exp=%b", i, obs, exp_v);
            end
            total++;
            if ({arb_if.SDA_out, arb_if.SCL_out} !== 2'b11) begin
                bad++; $display("FAIL idle_busy_pads[%0d] got=%b exp=%b", i, {arb_if.SDA_out, arb_if.SCL_out}, 2'b11);
            end
            if (i < 5) begin
                {arb_if.SCL_sync, arb_if.SDA_sync} = seq[i];
                exp_q.push_back(4'b0010);
                cyc();
            end
        end
        arb_if.SDA_sync = 1'b1;
        exp_q.push_back(4'b0000);
        exp_q.push_back(4'b1000);
        for (int i = 0; i < 2; i++) begin
            cyc();
            exp_v = exp_q.pop_front();
            total++;
            if (obs !== exp_v) begin
                bad++; $display("FAIL idle_stop[%0d] got=%b exp=%b", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_timeout();
        int n;
        arb_if.SDA_sync = 1'b0;
        exp_q.push_back(4'b1010);
        cyc();
        exp_v = exp_q.pop_front();
        total++;
        if (obs !== exp_v) begin
            bad++; $display("FAIL to_start got=%b exp=%b", obs, exp_v);
        end
        arb_if.SCL_sync = 1'b0;
`ifdef I2C_BUS_TIMEOUT_EN
        repeat (6) exp_q.push_back(4'b1010);
        exp_q.push_back(4'b1011);
        exp_q.push_back(4'b1000);
        exp_q.push_back(4'b1000);
`else
        repeat (12) exp_q.push_back(4'b1010);
`endif
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            cyc();
            exp_v = exp_q.pop_front();
            total++;
            if (obs !== exp_v) begin
                bad++; $display("FAIL scl_low[%0d] got=%b exp=%b", i, obs, exp_v);
            end
        end
        arb_if.SCL_sync = 1'b1;
`ifdef I2C_BUS_TIMEOUT_EN
        exp_q.push_back(4'b1000);
`else
        exp_q.push_back(4'b1010);
`endif
        cyc();
        arb_if.SDA_sync = 1'b1;
        exp_q.push_back(4'b1000);
        for (int i = 0; i < 2; i++) begin
            if (i > 0) cyc();
            exp_v = exp_q.pop_front();
            total++;
            if (obs !== exp_v) begin
                bad++; $display("FAIL to_release[%0d] got=%b exp=%b", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid();
        arb_if.SDA_sync = 1'b0;
        arb_if.busy_master = 1'b1;
        exp_q.push_back(4'b1010);
        cyc();
        exp_v = exp_q.pop_front();
        total++;
        if (obs !== exp_v) begin
            bad++; $display("FAIL mid_busy got=%b exp=%b", obs, exp_v);
        end
        #3;
        n_rst = 1'b0;
        #1;
        total++;
        if ({obs, arb_if.SDA_out, arb_if.SCL_out, arb_if.TX_read_enable} !== 7'b0000110) begin
            bad++; $display("FAIL mid_reset got=%b exp=%b", {obs, arb_if.SDA_out, arb_if.SCL_out,
                arb_if.TX_read_enable}, 7'b0000110);
        end
        arb_if.SCL_sync = 1'b0;
        arb_if.busy_master = 1'b0;
        cyc();
        n_rst = 1'b1;
        repeat (2) exp_q.push_back(4'b1000);
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                arb_if.SCL_sync = 1'b1;
                repeat (2) exp_q.push_back(4'b1000);
            end
            cyc();
            exp_v = exp_q.pop_front();
            total++;
            if (obs !== exp_v) begin
                bad++; $display("FAIL post_reset[%0d] got=%b exp=%b", i, obs, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_slave_mux();
        test_drain_abort();
        test_switch_s_to_m();
        test_master_drain();
        test_idle_busy();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_role_arbiter.md
Name:
i2c_role_arbiter

Overview:
- Shares the I2C pads (SDA/SCL) and the TX/RX FIFO ports between the master core and the slave core.
- Only one core is enabled at a time, selected by the `ms_select` config bit.
- A role change takes effect only after the active core is idle and the bus is free (STOP seen).
- Sits between the two cores and the FIFO/pad/status logic in the I2C top.

Parameters:
- TIMEOUT_CYCLES, 16'd50000: clk cycles SCL may stay low while bus_busy before forced release (used only with the optional feature).
- TO_W, 16: width of the timeout counter.

Ports:
- clk  in  1  system clock.
- n_rst  in  1  asynchronous active-low reset.
- ms_select  in  1  1 = master role requested, 0 = slave role requested.
- SDA_sync, SCL_sync  in  1 each  synchronized bus lines.
- busy_master, busy_slave  in  1 each  core busy flags.
- SDA_out_master, SCL_out_master, SDA_out_slave, SCL_out_slave  in  1 each  core pad drives (0 = pull low).
- TX_read_enable_master, TX_read_enable_slave  in  1 each  FIFO pop strobes.
- RX_write_enable_master, RX_write_enable_slave  in  1 each  FIFO push strobes.
- rx_data_master, rx_data_slave  in  8 each  receive bytes.
- set_transaction_complete_master/_slave, ack_error_set_master/_slave  in  1 each  status pulses.
- SDA_out, SCL_out  out  1 each  muxed pad drives.
- TX_read_enable, RX_write_enable  out  1 each  muxed FIFO strobes.
- rx_data  out  8  muxed receive byte.
- set_transaction_complete, ack_error_set  out  1 each  muxed status pulses.
- master_enable, slave_enable  out  1 each  core enables (one-hot or both 0).
- bus_busy  out  1  START seen, STOP not yet seen.
- bus_timeout  out  1  one-cycle pulse on timeout release (0 without the optional feature).

Behaviour:
- Bus monitor:
  - sda_prev is a register, reset value 1.
  - START = SCL_sync & sda_prev & ~SDA_sync; STOP = SCL_sync & ~sda_prev & SDA_sync.
  - bus_busy is set on START and cleared on STOP, registered (visible the cycle after detection).
  - A START while already busy (repeated START) keeps bus_busy at 1.
- State register: ARB_IDLE, ARB_MASTER, ARB_DRAIN_M, ARB_SLAVE, ARB_DRAIN_S.
  - ARB_IDLE → ARB_MASTER if ms_select & ~bus_busy; → ARB_SLAVE if ~ms_select & ~bus_busy; otherwise stay.
  - ARB_MASTER → ARB_DRAIN_M when ms_select == 0.
  - ARB_DRAIN_M → ARB_MASTER if ms_select returns to 1 (abort switch, takes priority); else → ARB_IDLE when ~busy_master & ~bus_busy.
  - ARB_SLAVE and ARB_DRAIN_S mirror this with polarity inverted and busy_slave.
- Enables:
  - master_enable = state ∈ {ARB_MASTER, ARB_DRAIN_M}.
  - slave_enable = state ∈ {ARB_SLAVE, ARB_DRAIN_S}.
  - Both are decoded from the state register, never from ms_select directly.
- Output mux:
  - Combinational from the state register, zero latency.
  - The selected core (including in its DRAIN state) drives all muxed outputs.
  - In ARB_IDLE: SDA_out = 1, SCL_out = 1, all strobes/pulses = 0, rx_data = 8'h00.
  - Non-selected core strobes are never forwarded.
- Reset values: state ARB_IDLE; master_enable = 0, slave_enable = 0, bus_busy = 0, bus_timeout = 0; SDA_out = 1, SCL_out = 1; all other outputs 0.
- Switch latency: with the old core idle and the bus free, a ms_select change applied before edge N gives:
  - DRAIN after edge N;
  - IDLE after edge N+1;
  - new enable high after edge N+2.
  - Exactly one IDLE cycle with both enables low.
- Reset asserted mid-transaction: immediate return to reset values; bus_busy reads 0 until the next START.

Optional Feature:
- I2C_BUS_TIMEOUT_EN defined:
  - A TO_W counter increments while bus_busy & ~SCL_sync and clears otherwise.
  - On reaching TIMEOUT_CYCLES-1: bus_busy is cleared, bus_timeout pulses for 1 cycle, and the counter clears.
  - Any DRAIN state whose core is not busy may then exit.
- I2C_BUS_TIMEOUT_EN undefined: no counter is built; bus_timeout is tied to 0; bus_busy clears only on STOP.

Decomposition:
- Package i2c_arb_pkg holds: typedef enum logic [2:0] arb_state_t (the five states) and localparam SDA_RELEASED = 1'b1.
- One sub-module, i2c_bus_monitor (sda_prev, START/STOP detection, bus_busy, optional timeout counter), instantiated once.
- Mux and FSM stay in the top-level module.

Test Plan:
- Reset with ms_select = 0, bus idle → after n_rst rises: slave_enable = 1 on the 1st edge, master_enable = 0; SDA_out = SCL_out = 1 during reset.
- In ARB_MASTER, drive START (SCL = 1, SDA 1→0), set ms_select = 0, busy_master = 1 for 20 cycles, then STOP:
  - master_enable stays 1 until the edge after both busy_master = 0 and bus_busy = 0;
  - followed by 1 IDLE cycle, then slave_enable = 1.
- In ARB_DRAIN_S with busy_slave = 1, return ms_select to 0 → next edge ARB_SLAVE; master_enable never asserts.
- In ARB_SLAVE, TX_read_enable_master = 1 and rx_data_master = 8'hA5 → TX_read_enable = 0 and rx_data = rx_data_slave (8'h3C).
- ARB_IDLE with bus_busy = 1 (external START) and ms_select = 1 → stays IDLE with SDA_out = SCL_out = 1 until STOP; master_enable = 1 two edges after STOP.
- I2C_BUS_TIMEOUT_EN with TIMEOUT_CYCLES = 8: START, then hold SCL = 0 → bus_timeout pulses on the 8th low cycle and bus_busy = 0 the cycle after; without the macro, bus_busy stays 1.
